// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the sobel pixel pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  // Width needed to index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// x/y raster position of the pixel stream with first/last flags for markers.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic adv_x,
  input  logic adv_y,
  input  logic clr_y,
  output logic x_first,
  output logic x_last,
  output logic y_first,
  output logic y_last
);

  localparam int XW = cnt_width(LINE_WIDTH);
  localparam int YW = cnt_width(FRAME_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign x_first = (x == '0);
  assign x_last  = (x == X_LAST);
  assign y_first = (y == '0);
  assign y_last  = (y == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else begin
      if (clear)
        x <= '0;
      else if (adv_x)
        x <= x_last ? '0 : x + XW'(1);

      if (clear || clr_y)
        y <= '0;
      else if (adv_y)
        y <= y + YW'(1);
    end
  end

endmodule

// File: rtl/pix_stream_tx.sv
// Frame-paced pixel transmitter: paces an upstream pixel stream into lines and
// frames with blanking gaps and registered line/frame markers.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for enable to start a frame
//   ST_ACTIVE | accepting pixels of the current line
//   ST_HBLANK | idle gap after a non-final line
//   ST_VBLANK | idle gap after the final line; enable sampled on last cycle
module pix_stream_tx
  import sobel_pkg::*;
#(
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080,
  parameter int DATA_WIDTH   = 8,
  parameter int HBLANK       = 280,
  parameter int VBLANK       = 45
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  line_start,
  output logic                  line_end,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy,
  output logic [15:0]           stall_cnt
);

  localparam int BW = cnt_width((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam logic [BW-1:0] H_LOAD = BW'(HBLANK - 1);
  localparam logic [BW-1:0] V_LOAD = BW'(VBLANK - 1);

  state_t        state;
  logic [BW-1:0] blank_cnt;
  logic          accept;
  logic          blank_done;
  logic          frame_go;
  logic          adv_y;
  logic          clr_y;
  logic          x_first;
  logic          x_last;
  logic          y_first;
  logic          y_last;

  assign s_ready    = (state == ST_ACTIVE);
  assign busy       = (state != ST_IDLE);
  assign accept     = s_valid & s_ready;
  assign blank_done = (blank_cnt == '0);
  assign frame_go   = (state == ST_IDLE) & enable;
  assign adv_y      = (state == ST_HBLANK) & blank_done;
  assign clr_y      = (state == ST_VBLANK) & blank_done;

  raster_counter #(
    .LINE_WIDTH   (LINE_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (frame_go),
    .adv_x   (accept),
    .adv_y   (adv_y),
    .clr_y   (clr_y),
    .x_first (x_first),
    .x_last  (x_last),
    .y_first (y_first),
    .y_last  (y_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      blank_cnt   <= '0;
      stall_cnt   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      data_valid  <= accept;
      line_start  <= accept & x_first;
      line_end    <= accept & x_last;
      frame_start <= accept & x_first & y_first;
      frame_end   <= accept & x_last & y_last;
      if (accept)
        data_out <= s_data;

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state     <= ST_ACTIVE;
            stall_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (!s_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
          if (accept && x_last) begin
            state     <= y_last ? ST_VBLANK : ST_HBLANK;
            blank_cnt <= y_last ? V_LOAD : H_LOAD;
          end
        end
        ST_HBLANK: begin
          if (blank_done)
            state <= ST_ACTIVE;
          else
            blank_cnt <= blank_cnt - BW'(1);
        end
        ST_VBLANK: begin
          // enable only matters here: a running frame always completes
          if (blank_done)
            state <= enable ? ST_ACTIVE : ST_IDLE;
          else
            blank_cnt <= blank_cnt - BW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_stream_tx.sv
// Directed bench for pix_stream_tx with a 4x3 frame, HBLANK=2, VBLANK=5.
module tb_pix_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        line_start;
  logic        line_end;
  logic        frame_start;
  logic        frame_end;
  logic        busy;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int src      = 0;

  always #5 clk = ~clk;

  pix_stream_tx #(
    .LINE_WIDTH   (4),
    .FRAME_HEIGHT (3),
    .DATA_WIDTH   (8),
    .HBLANK       (2),
    .VBLANK       (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .line_start  (line_start),
    .line_end    (line_end),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  // One clock; the source presents the next pixel index once the current one is taken.
  task automatic tick();
    bit acc;
    acc = s_valid && s_ready;
    @(posedge clk);
    @(negedge clk);
    if (acc) begin
      src    = src + 1;
      s_data = 8'(src % 12);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    src     = 0;
    s_data  = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    repeat (2) @(negedge clk);
    n_checks++;
    if (data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out);
    end
    n_checks++;
    if ({data_valid, line_start, line_end, frame_start, frame_end} !== 5'b0) begin
      n_fail++; $display("FAIL reset_markers: got %b want 00000",
                         {data_valid, line_start, line_end, frame_start, frame_end});
    end
    n_checks++;
    if ({busy, s_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_ready: got %b want 00", {busy, s_ready});
    end
    n_checks++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_continuous();
    string pat = "01111001111001111000001";
    int exp_idx = 0;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      tick();
      n_checks++;
      if (data_valid !== 1'(pat[n-1] == "1")) begin
        n_fail++; $display("FAIL cont_valid cycle %0d: got %b want %c", n, data_valid, pat[n-1]);
      end
      if (data_valid) begin
        n_checks++;
        if (data_out !== 8'(exp_idx % 12)) begin
          n_fail++; $display("FAIL cont_data cycle %0d: got %0d want %0d", n, data_out, exp_idx % 12);
        end
        exp_idx++;
      end else if (exp_idx > 0) begin
        n_checks++;
        if (data_out !== 8'((exp_idx - 1) % 12)) begin
          n_fail++; $display("FAIL cont_hold cycle %0d: got %0d want %0d", n, data_out, (exp_idx - 1) % 12);
        end
      end
    end
    n_checks++;
    if (exp_idx !== 13) begin
      n_fail++; $display("FAIL cont_count: got %0d want 13", exp_idx);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL cont_busy: got %b want 1", busy);
    end
  endtask

  task automatic test_stall();
    string pat = "01111001100011001111";
    int exp_idx = 0;
    int stall_left = 3;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (src == 6 && stall_left > 0) begin
        s_valid = 1'b0;
        stall_left--;
      end else begin
        s_valid = 1'b1;
      end
      tick();
      n_checks++;
      if (data_valid !== 1'(pat[n-1] == "1")) begin
        n_fail++; $display("FAIL stall_valid cycle %0d: got %b want %c", n, data_valid, pat[n-1]);
      end
      if (data_valid) begin
        n_checks++;
        if (data_out !== 8'(exp_idx)) begin
          n_fail++; $display("FAIL stall_data cycle %0d: got %0d want %0d", n, data_out, exp_idx);
        end
        n_checks++;
        if (line_end !== 1'(exp_idx % 4 == 3)) begin
          n_fail++; $display("FAIL stall_line_end pixel %0d: got %b want %b", exp_idx, line_end, exp_idx % 4 == 3);
        end
        exp_idx++;
      end
    end
    n_checks++;
    if (stall_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int exp_idx = 0;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (data_valid) begin
        n_checks++;
        if (data_out !== 8'(exp_idx)) begin
          n_fail++; $display("FAIL drop_data cycle %0d: got %0d want %0d", n, data_out, exp_idx);
        end
        if (data_out == 8'd5) enable = 1'b0;
        exp_idx++;
      end
    end
    n_checks++;
    if (exp_idx !== 12) begin
      n_fail++; $display("FAIL drop_count: got %0d want 12", exp_idx);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_busy: got %b want 0", busy);
    end
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL drop_ready: got %b want 0", s_ready);
    end
  endtask

  task automatic test_reset_midframe();
    bit found = 1'b0;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (data_valid && data_out == 8'd7) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL midrst_reach_pixel7: got none want pixel 7");
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (data_out !== 8'h00) begin
      n_fail++; $display("FAIL midrst_data_out: got %h want 00", data_out);
    end
    n_checks++;
    if ({data_valid, line_start, line_end, frame_start, frame_end, busy, s_ready} !== 7'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b want 0000000",
                         {data_valid, line_start, line_end, frame_start, frame_end, busy, s_ready});
    end
    @(negedge clk);
    rst    = 1'b1;
    src    = 0;
    s_data = 8'd0;
    found  = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (data_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL midrst_restart: got no output want pixel 0 within 10 cycles");
    end
    n_checks++;
    if ({frame_start, line_start, data_out} !== {1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL midrst_first_pixel: got fs=%b ls=%b data=%0d want fs=1 ls=1 data=0",
                         frame_start, line_start, data_out);
    end
  endtask

  task automatic test_markers();
    int exp_idx = 0;
    do_reset();
    enable  = 1'b1;
    s_valid = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      tick();
      if (!data_valid) begin
        n_checks++;
        if ({line_start, line_end, frame_start, frame_end} !== 4'b0) begin
          n_fail++; $display("FAIL mark_idle cycle %0d: got %b want 0000", n,
                             {line_start, line_end, frame_start, frame_end});
        end
      end else begin
        n_checks++;
        if ({line_start, line_end, frame_start, frame_end} !==
            {1'(exp_idx % 4 == 0), 1'(exp_idx % 4 == 3), 1'(exp_idx == 0), 1'(exp_idx == 11)}) begin
          n_fail++; $display("FAIL mark_pixel %0d: got ls/le/fs/fe=%b", exp_idx,
                             {line_start, line_end, frame_start, frame_end});
        end
        exp_idx++;
      end
    end
    n_checks++;
    if (exp_idx !== 12) begin
      n_fail++; $display("FAIL mark_count: got %0d want 12", exp_idx);
    end
  endtask

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'd0;
    test_reset();
    test_continuous();
    test_stall();
    test_enable_drop();
    test_reset_midframe();
    test_markers();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pix_stream_tx.md
PIX_STREAM_TX -- requirements
Module: pix_stream_tx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst.
REQ-002 Parameter LINE_WIDTH, default 1920, sets the number of active pixels per line.
REQ-003 Parameter FRAME_HEIGHT, default 1080, sets the number of active lines per frame.
REQ-004 Parameter DATA_WIDTH, default 8, sets the pixel width in bits.
REQ-005 Parameter HBLANK, default 280, sets the idle cycles after each non-final line; legal range is 1 or more.
REQ-006 Parameter VBLANK, default 45, sets the idle cycles after the final line of a frame; legal range is 1 or more.
REQ-007 The ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  permits a new frame to start
- s_data  in  DATA_WIDTH  upstream pixel
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- data_out  out  DATA_WIDTH  pixel to the line_delay/sobel chain
- data_valid  out  1  data_out valid
- line_start  out  1  asserted with the first pixel of each line
- line_end  out  1  asserted with the last pixel of each line
- frame_start  out  1  asserted with pixel (0,0)
- frame_end  out  1  asserted with the last pixel of the frame
- busy  out  1  high whenever the state is not IDLE
- stall_cnt  out  16  saturating count of ACTIVE cycles in which s_valid was low

Function
REQ-008 The state machine SHALL have four states: IDLE, ACTIVE, HBLANK and VBLANK.
REQ-009 IDLE SHALL go to ACTIVE when enable=1; x, y and stall_cnt SHALL clear on that transition.
REQ-010 s_ready SHALL equal (state==ACTIVE), combinationally; a pixel is accepted when s_valid and s_ready are both 1.
REQ-011 Each accepted pixel SHALL appear on data_out with data_valid=1 exactly one cycle later; data_out SHALL hold its last value when data_valid=0.
REQ-012 x SHALL increment only on an accepted pixel; an ACTIVE cycle with s_valid=0 SHALL produce no output, SHALL NOT advance x, and SHALL increment stall_cnt, saturating at 0xFFFF.
REQ-013 Accepting the pixel at x=LINE_WIDTH-1 SHALL reset x to 0; the state SHALL then go to HBLANK if y<FRAME_HEIGHT-1, or to VBLANK if y=FRAME_HEIGHT-1.
REQ-014 HBLANK SHALL last exactly HBLANK cycles, then increment y and return to ACTIVE; s_ready SHALL be 0 during HBLANK.
REQ-015 VBLANK SHALL last exactly VBLANK cycles, then clear y and go to ACTIVE if enable=1 or to IDLE if enable=0; enable is sampled in the last VBLANK cycle.
REQ-016 Deasserting enable during ACTIVE or HBLANK SHALL NOT truncate the frame; frames are always delivered complete.
REQ-017 line_start, line_end, frame_start and frame_end SHALL be registered, aligned with data_valid, and asserted only when data_valid=1.
REQ-018 For LINE_WIDTH=1, line_start and line_end SHALL assert together; for FRAME_HEIGHT=1, frame_start and frame_end SHALL follow the same rule at pixel (0,0).
REQ-019 The x counter SHALL be $clog2(LINE_WIDTH) bits wide, y SHALL be $clog2(FRAME_HEIGHT) bits, and the blank counter SHALL be sized to max(HBLANK,VBLANK); every compare SHALL be exact with no modulo-2^n wrap.

Reset
REQ-020 Asserting rst SHALL set the state to IDLE, clear x, y, the blank counter and stall_cnt, and drive every output low, including data_out.
REQ-021 A reset asserted mid-frame SHALL abort the frame immediately; after release, the next frame SHALL start at (0,0) with frame_start asserted.

Structure
REQ-022 The state enumeration and a counter-width helper SHALL live in the shared package sobel_pkg.
REQ-023 The x/y raster counting with its end-of-line and end-of-frame flags SHALL be one sub-module named raster_counter; the FSM and output registers SHALL stay in pix_stream_tx.

Verification
All scenarios use LINE_WIDTH=4, FRAME_HEIGHT=3, HBLANK=2 and VBLANK=5.
REQ-024 Scenario: continuous s_valid with pixels 0..11 and enable held high -> 3 bursts of 4 data_valid pulses separated by 2-cycle gaps; data_out is 0..11; the next frame starts after 5 idle cycles.
REQ-025 Scenario: s_valid low for 3 cycles at x=2 of line 1 -> output gap of 3 cycles; stall_cnt=3; pixel order unchanged; line_end still on the 4th pixel.
REQ-026 Scenario: enable dropped at pixel 5 -> remaining pixels 6..11 still delivered, then IDLE, busy=0, and s_ready=0 afterward.
REQ-027 Scenario: rst asserted at pixel 7 -> all outputs 0 immediately; after release with enable=1, the first output carries frame_start=1 and line_start=1 at x=0, y=0.
REQ-028 Scenario: markers check -> frame_start only with pixel 0, frame_end only with pixel 11, line_start with pixels 0, 4 and 8, line_end with pixels 3, 7 and 11.
